shift_mul_seq: RTL and testbench
================================

SHIFT_MUL_SEQ -- requirements
Module: shift_mul_seq

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning input data width.
REQ-002 The block SHALL have parameter NCOEF, default 4, meaning coefficients per input word (range 1..16).
REQ-003 The block SHALL have parameter CW, default 4, meaning coefficient width in bits (unsigned).
REQ-004 The block SHALL have parameter COEFS, default {4'd8,4'd7,4'd3,4'd1}, meaning a packed NCOEF*CW vector with coefficient 0 in the LSBs.
REQ-005 The block SHALL have parameter OUT_W, default DW+CW, meaning result width (OUT_W <= DW+CW).
REQ-006 Port clk: input, 1 bit, clock; all state updates on the rising edge.
REQ-007 Port rst: input, 1 bit, reset, asynchronous, active-low.
REQ-008 Port in_valid: input, 1 bit, input word present.
REQ-009 Port in_ready: output, 1 bit, block can accept a word this cycle.
REQ-010 Port d: input, DW bits, unsigned operand.
REQ-011 Port out_valid: output, 1 bit, out_data/out_idx/out_last valid.
REQ-012 Port out_ready: input, 1 bit, downstream accepts the current result.
REQ-013 Port out_data: output, OUT_W bits, product d*COEF[out_idx].
REQ-014 Port out_idx: output, clog2(NCOEF) bits (min 1), coefficient index of out_data.
REQ-015 Port out_last: output, 1 bit, high when out_idx == NCOEF-1.

Function
REQ-016 The block SHALL implement states IDLE and EMIT.
REQ-017 in_ready SHALL be combinational: 1 in IDLE; 1 in EMIT only when out_valid && out_ready && out_last; 0 otherwise.
REQ-018 On an edge with in_valid && in_ready, the block SHALL capture d, enter EMIT, and register out_data=d*COEF[0], out_idx=0, out_valid=1 (latency 1 cycle from accept to first result).
REQ-019 In EMIT, on an edge with out_valid && out_ready && !out_last, the block SHALL increment out_idx and register out_data=d_captured*COEF[out_idx+1].
REQ-020 On an edge with out_valid && out_ready && out_last: with in_valid=1, the block SHALL accept the new word per REQ-018 (no bubble); otherwise it SHALL return to IDLE with out_valid=0.
REQ-021 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-022 Products SHALL be formed by shift-and-add over coefficient bits, without a multiply operator, at full width DW+CW, then reduced to OUT_W per REQ-027/028.
REQ-023 Zero coefficients SHALL still emit a result (out_data=0); d=0 SHALL emit NCOEF zero results.
REQ-024 in_valid while in_ready=0 SHALL be ignored; the source holds d until accepted.

Reset
REQ-025 While rst=0 the block SHALL force IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, captured operand=0, regardless of clk.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence; the first edge after release with in_valid=1 SHALL start a new sequence at index 0.

Configuration
REQ-027 With SHIFT_MUL_SEQ_SAT_EN defined, a full-width product exceeding 2^OUT_W-1 SHALL output 2^OUT_W-1.
REQ-028 Without SHIFT_MUL_SEQ_SAT_EN, out_data SHALL be the low OUT_W bits of the product (modulo wrap).

Structure
REQ-029 Package shift_mul_seq_pkg SHALL hold the state enumeration, the default coefficient vector, and a clog2-based index-width function.
REQ-030 Sub-module shift_add_mul (combinational DW x CW shift-and-add multiplier, DW+CW output) SHALL compute products; saturation/truncation and all sequencing SHALL stay in shift_mul_seq.

Verification
REQ-031 Defaults, d=5, out_ready=1: out_data 5,15,35,40 on 4 consecutive cycles, out_idx 0..3, out_last only with 40.
REQ-032 Defaults, d=5, out_ready low 3 cycles while out_data=15: out_data=15, out_idx=1 held; in_ready=0; sequence resumes with 35.
REQ-033 Defaults, d=5 then d=200 held valid: 200 accepted on the edge emitting 40; next outputs 200,600,1400,1600 with no idle cycle.
REQ-034 OUT_W=10, d=255, coefficient 7: with SHIFT_MUL_SEQ_SAT_EN out_data=1023; without, out_data=761.
REQ-035 Defaults, rst low while out_idx=2: out_valid=0, out_data=0 immediately; after release in_ready=1 and d=3 yields 3,9,21,24.
REQ-036 NCOEF=1, COEFS=4'd0, d=9: single result 0 with out_last=1, then IDLE.

Source files
------------

// File: rtl/shift_mul_seq_pkg.sv
// Shared types and constants for the shift-and-add coefficient sequencer.
// Used by shift_mul_seq and shift_add_mul.
package shift_mul_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Coefficient 0 sits in the LSBs: {8, 7, 3, 1}.
    localparam logic [15:0] DEF_COEFS = {4'd8, 4'd7, 4'd3, 4'd1};

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Combinational unsigned DW x CW multiplier built from shifted partial sums.
// Produces the full-width DW+CW product; any reduction happens in the caller.
module shift_add_mul
    import shift_mul_seq_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic [DW-1:0]    i_a,
    input  logic [CW-1:0]    i_b,
    output logic [DW+CW-1:0] o_p
);

    logic [DW+CW-1:0] w_acc;
    logic [DW+CW-1:0] w_a_ext;

    assign w_a_ext = {{CW{1'b0}}, i_a};

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < CW; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc + (w_a_ext << i);
            end
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/shift_mul_seq.sv
// Emits d*COEF[0..NCOEF-1] one result per handshake after each accepted word.
// Define SHIFT_MUL_SEQ_SAT_EN to saturate results at 2^OUT_W-1 instead of wrapping.
module shift_mul_seq
    import shift_mul_seq_pkg::*;
#(
    parameter int                  DW    = 8,
    parameter int                  NCOEF = 4,
    parameter int                  CW    = 4,
    parameter logic [NCOEF*CW-1:0] COEFS = DEF_COEFS,
    parameter int                  OUT_W = DW + CW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [idx_width(NCOEF)-1:0]   out_idx,
    output logic                          out_last
);

    localparam int            IW       = idx_width(NCOEF);
    localparam int            PW       = DW + CW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    function automatic logic [OUT_W-1:0] reduce_prod(input logic [PW-1:0] full);
`ifdef SHIFT_MUL_SEQ_SAT_EN
        if ((full >> OUT_W) != '0) begin
            return '1;
        end
`endif
        return full[OUT_W-1:0];
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_d;
    logic [IW-1:0]    r_idx;
    logic [OUT_W-1:0] r_data;
    logic             r_last;

    logic             w_accept;
    logic             w_advance;
    logic [IW-1:0]    w_sel;
    logic [CW-1:0]    w_coef;
    logic [DW-1:0]    w_mul_a;
    logic [PW-1:0]    w_prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepting on the final handshake lets a new word follow without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_EMIT: begin
                in_ready  = out_ready && r_last;
                w_advance = out_ready && !r_last;
                if (out_ready && r_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_accept = in_valid && in_ready;
        if (w_accept) begin
            w_state_nxt = ST_EMIT;
        end
    end

    // One multiplier serves both the first product and every later step.
    always_comb begin
        w_sel  = w_accept ? '0 : (r_last ? r_idx : r_idx + IDX_ONE);
        w_coef = '0;
        for (int i = 0; i < NCOEF; i++) begin
            if (w_sel == IW'(i)) begin
                w_coef = COEFS[i*CW +: CW];
            end
        end
    end

    assign w_mul_a = w_accept ? d : r_d;

    shift_add_mul #(
        .DW (DW),
        .CW (CW)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (w_coef),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d    <= '0;
            r_idx  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_d    <= d;
            r_idx  <= '0;
            r_data <= reduce_prod(w_prod);
            r_last <= (LAST_IDX == '0);
        end else if (w_advance) begin
            r_idx  <= r_idx + IDX_ONE;
            r_data <= reduce_prod(w_prod);
            r_last <= ((r_idx + IDX_ONE) == LAST_IDX);
        end
    end

    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

endmodule

// File: tb/tb_shift_mul_seq.sv
// Bench for shift_mul_seq: directed sequences plus randomized handshakes against a queue model.
// Honors SHIFT_MUL_SEQ_SAT_EN in its expected values.
module tb_shift_mul_seq;

    localparam int NCOEF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0]  d;
    logic [11:0] out_data;
    logic [1:0]  out_idx;

    logic        iv2, ir2, ov2, or2, ol2;
    logic [7:0]  d2;
    logic [9:0]  od2;
    logic [1:0]  oi2;

    logic        iv3, ir3, ov3, or3, ol3;
    logic [7:0]  d3;
    logic [11:0] od3;
    logic [0:0]  oi3;

    shift_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    shift_mul_seq #(.OUT_W(10)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .d(d2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_idx(oi2), .out_last(ol2)
    );

    shift_mul_seq #(.NCOEF(1), .COEFS(4'd0)) dut_one (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .d(d3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3),
        .out_idx(oi3), .out_last(ol3)
    );

    typedef struct {
        int data;
        int idx;
        bit last;
    } res_t;

    res_t q[$];
    int   coefs[NCOEF] = '{1, 3, 7, 8};
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic int ref_prod(input int dv, input int c, input int ow);
        int full;
        int lim;
        full = dv * c;
        lim  = (1 << ow) - 1;
`ifdef SHIFT_MUL_SEQ_SAT_EN
        return (full > lim) ? lim : full;
`else
        return full & lim;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One clock of the main DUT: apply inputs, compare against the model, step the model.
    task automatic cycle(input bit iv, input int dv, input bit ordy, output bit acc);
        bit exp_rdy;
        in_valid  = iv;
        d         = dv[7:0];
        out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(q[0].data));
            check("out_idx",  32'(out_idx),  32'(q[0].idx));
            check("out_last", 32'(out_last), 32'(q[0].last));
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = iv && exp_rdy;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < NCOEF; k++) begin
                q.push_back('{ref_prod(dv, coefs[k], 12), k, (k == NCOEF - 1)});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit dummy;
        bit pend;
        bit pv;
        int pd;
        int seq33[8] = '{5, 15, 35, 40, 200, 600, 1400, 1600};
        int seq31[4] = '{5, 15, 35, 40};
        int seq35[4] = '{3, 9, 21, 24};
        int sat_exp;

        rst = 1'b1;
        in_valid = 0; d = 0; out_ready = 0;
        iv2 = 0; d2 = 0; or2 = 0;
        iv3 = 0; d3 = 0; or3 = 0;
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_idx",   32'(out_idx),   0);
        check("rst_out_last",  32'(out_last),  0);
        check("rst_in_ready",  32'(in_ready),  1);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back results with downstream always ready.
        cycle(1, 5, 1, dummy);
        for (int i = 0; i < 4; i++) begin
            check("seq31_data", 32'(out_data), 32'(seq31[i]));
            cycle(0, 0, 1, dummy);
        end

        // Backpressure while index 1 is presented.
        cycle(1, 5, 1, dummy);
        cycle(0, 0, 1, dummy);
        for (int i = 0; i < 3; i++) cycle(1, 77, 0, dummy);
        check("stall_idx", 32'(out_idx), 1);
        cycle(0, 0, 1, dummy);
        check("resume_data", 32'(out_data), 35);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, dummy);

        // Next word accepted on the final handshake with no idle cycle.
        cycle(1, 5, 1, dummy);
        for (int i = 0; i < 8; i++) begin
            check("seq33_data", 32'(out_data), 32'(seq33[i]));
            cycle(i < 4, 200, 1, dummy);
        end

        // Reset in the middle of a sequence.
        cycle(1, 5, 1, dummy);
        cycle(0, 0, 1, dummy);
        cycle(0, 0, 1, dummy);
        check("pre_rst_idx", 32'(out_idx), 2);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data",  32'(out_data),  0);
        check("midrst_idx",   32'(out_idx),   0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 3, 1, dummy);
        for (int i = 0; i < 4; i++) begin
            check("seq35_data", 32'(out_data), 32'(seq35[i]));
            cycle(0, 0, 1, dummy);
        end

        // Randomized handshakes; the source holds d until it is taken.
        pend = 0;
        pv = 0;
        pd = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pend) begin
                pv = ($urandom_range(0, 1) == 1);
                pd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            end
            cycle(pv, pd, ($urandom_range(0, 3) != 0), dummy);
            pend = pv && !dummy;
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, dummy);

        // Narrow output: saturate or wrap on 255*7.
`ifdef SHIFT_MUL_SEQ_SAT_EN
        sat_exp = 1023;
`else
        sat_exp = 761;
`endif
        iv2 = 1; d2 = 8'd255; or2 = 1;
        @(negedge clk);
        iv2 = 0;
        for (int k = 0; k < NCOEF; k++) begin
            check("nar_valid", 32'(ov2), 1);
            check("nar_data",  32'(od2), 32'(ref_prod(255, coefs[k], 10)));
            check("nar_idx",   32'(oi2), 32'(k));
            check("nar_last",  32'(ol2), 32'(k == NCOEF - 1));
            if (k == 2) check("nar_coef7", 32'(od2), 32'(sat_exp));
            @(negedge clk);
        end
        check("nar_idle", 32'(ov2), 0);

        // Single zero coefficient.
        iv3 = 1; d3 = 8'd9; or3 = 1;
        @(negedge clk);
        iv3 = 0;
        check("one_valid", 32'(ov3), 1);
        check("one_data",  32'(od3), 0);
        check("one_last",  32'(ol3), 1);
        check("one_idx",   32'(oi3), 0);
        check("one_ready", 32'(ir3), 1);
        @(negedge clk);
        check("one_idle",  32'(ov3), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
